usb_tx_scheduler: RTL and testbench
===================================

USB_TX_SCHEDULER -- requirements
Module: usb_tx_scheduler

Interface
REQ-001 The block SHALL use one clock (clk) and an asynchronous, active-high reset (rst).
REQ-002 Parameter IPG_CYCLES, default 8: idle cycles enforced between packets (range 1..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: WAIT_END cycles before abort (range 2..65535).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 hs_req  in  1  handshake request, level, held until hs_ack.
REQ-007 hs_pid  in  2  0=ACK, 1=NAK, 2=STALL, 3=reserved.
REQ-008 data_req  in  1  DATA0 request, level, held until data_ack.
REQ-009 data_len  in  7  payload bytes for the DATA0 request (0 = zero-length packet).
REQ-010 buffer_occupancy  in  7  bytes currently in the TX FIFO.
REQ-011 end_packet  in  1  one-cycle pulse from encoder at packet completion.
REQ-012 begin_packet  out  1  one-cycle start strobe to encoder.
REQ-013 tx_packet  out  3  packet type to encoder: 0=none, 1=DATA0, 2=ACK, 3=NAK, 4=STALL.
REQ-014 hs_ack  out  1  one-cycle pulse: handshake request completed.
REQ-015 data_ack  out  1  one-cycle pulse: DATA0 request completed.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 tx_timeout  out  1  one-cycle pulse: encoder failed to signal end_packet in time.

Function
REQ-018 FSM SHALL have states IDLE, LAUNCH, WAIT_END, GAP; all outputs SHALL be registered or decoded from state and registers only.
REQ-019 IDLE, arbitration: hs_req with hs_pid!=3 SHALL win over data_req; data_req SHALL be eligible only when buffer_occupancy >= data_len.
REQ-020 IDLE, winner found: latch type (hs_pid mapped 0->2, 1->3, 2->4; data->1) and owner, go to LAUNCH next cycle.
REQ-021 IDLE, hs_req with hs_pid==3: pulse hs_ack next cycle, no transmission, stay IDLE; data_req in the same cycle SHALL be deferred one cycle.
REQ-022 LAUNCH SHALL last exactly one cycle with begin_packet=1, clear timeout counter, then go to WAIT_END.
REQ-023 tx_packet SHALL equal the latched type during LAUNCH and WAIT_END and 0 in IDLE and GAP.
REQ-024 WAIT_END, end_packet=1: pulse hs_ack or data_ack (latched owner only) next cycle, go to GAP.
REQ-025 WAIT_END, timeout counter reaching TIMEOUT_CYCLES-1 without end_packet: pulse tx_timeout, no ack, go to GAP; requester remains pending.
REQ-026 end_packet and timeout expiry in the same cycle: end_packet SHALL win (ack, no tx_timeout).
REQ-027 GAP SHALL last exactly IPG_CYCLES cycles, then go to IDLE.
REQ-028 end_packet in IDLE, LAUNCH or GAP SHALL be ignored.
REQ-029 Requests and hs_pid/data_len SHALL be sampled only in IDLE; changes in other states SHALL have no effect on the packet in flight.
REQ-030 Latency: request first valid at edge N in IDLE -> begin_packet high in cycle N+1; end_packet at edge M -> ack high in cycle M+1.
REQ-031 A request still asserted when GAP returns to IDLE SHALL be treated as a new request.
REQ-032 Counters SHALL be sized to hold TIMEOUT_CYCLES-1 and IPG_CYCLES without wrap.

Reset
REQ-033 rst=1 SHALL force state IDLE, counters 0, latched type 0, and begin_packet, tx_packet, hs_ack, data_ack, busy, tx_timeout to 0.
REQ-034 Reset asserted mid-packet SHALL abort silently: no ack or tx_timeout on or after deassertion.
REQ-035 After rst deassertion the first arbitration SHALL occur at the first clk edge with rst=0.

Verification
REQ-036 hs_req=1, hs_pid=1 in IDLE -> begin_packet 1 cycle later, tx_packet=3; end_packet -> hs_ack next cycle, busy high for exactly 8 more cycles.
REQ-037 hs_req (pid 0) and data_req (len 4, occupancy 10) simultaneous -> ACK sent first (tx_packet=2); DATA0 starts 1 cycle after GAP ends.
REQ-038 data_req, data_len=20, occupancy 19 -> no begin_packet; occupancy 20 -> begin_packet next cycle, tx_packet=1.
REQ-039 DATA0 launched, no end_packet -> tx_timeout pulse at WAIT_END cycle 1024, no data_ack, relaunch after GAP.
REQ-040 end_packet on the expiry cycle -> data_ack, tx_timeout stays 0.
REQ-041 rst pulsed during WAIT_END -> all outputs 0 immediately; late end_packet produces no ack.

Source files
------------

// File: rtl/usb_tx_scheduler.sv
// USB transmit scheduler: arbitrates handshake and DATA0 requests, launches one
// packet at a time to the encoder, waits for completion or timeout, then enforces an inter-packet gap.
module usb_tx_scheduler #(
  parameter int IPG_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_req,
  input  logic [1:0] hs_pid,
  input  logic       data_req,
  input  logic [6:0] data_len,
  input  logic [6:0] buffer_occupancy,
  input  logic       end_packet,
  output logic       begin_packet,
  output logic [2:0] tx_packet,
  output logic       hs_ack,
  output logic       data_ack,
  output logic       busy,
  output logic       tx_timeout
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES - 1 > IPG_CYCLES) ? TIMEOUT_CYCLES - 1 : IPG_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_END, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    pkt_type;
  logic          owner_hs;
  logic          hs_valid;
  logic          hs_rsvd;
  logic          data_ok;

  // A reserved-PID request is masked while its ack is visible, so the
  // requester has one cycle to drop hs_req before it could be acked again.
  always_comb begin
    hs_valid = hs_req && !hs_ack && (hs_pid != 2'd3);
    hs_rsvd  = hs_req && !hs_ack && (hs_pid == 2'd3);
    data_ok  = data_req && (buffer_occupancy >= data_len);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pkt_type   <= '0;
      owner_hs   <= 1'b0;
      hs_ack     <= 1'b0;
      data_ack   <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      hs_ack     <= 1'b0;
      data_ack   <= 1'b0;
      tx_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (hs_valid) begin
            pkt_type <= {1'b0, hs_pid} + 3'd2;
            owner_hs <= 1'b1;
            state    <= LAUNCH;
          end else if (hs_rsvd) begin
            hs_ack <= 1'b1;
          end else if (data_ok) begin
            pkt_type <= 3'd1;
            owner_hs <= 1'b0;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT_END;
        end
        WAIT_END: begin
          // end_packet takes priority over a coincident timeout expiry
          if (end_packet) begin
            hs_ack   <= owner_hs;
            data_ack <= !owner_hs;
            cnt      <= '0;
            state    <= GAP;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            tx_timeout <= 1'b1;
            cnt        <= '0;
            state      <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == CW'(IPG_CYCLES - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign begin_packet = (state == LAUNCH);
  assign tx_packet    = (state == LAUNCH || state == WAIT_END) ? pkt_type : 3'd0;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Scoreboard bench for usb_tx_scheduler: directed stimulus pushes timed expected
// events; a negedge monitor pops and compares every strobe the DUT raises.
module tb_usb_tx_scheduler;

  logic       clk;
  logic       rst;
  logic       hs_req;
  logic [1:0] hs_pid;
  logic       data_req;
  logic [6:0] data_len;
  logic [6:0] buffer_occupancy;
  logic       end_packet;
  logic       begin_packet;
  logic [2:0] tx_packet;
  logic       hs_ack;
  logic       data_ack;
  logic       busy;
  logic       tx_timeout;

  usb_tx_scheduler #(.IPG_CYCLES(8), .TIMEOUT_CYCLES(1024)) dut (
    .clk              (clk),
    .rst              (rst),
    .hs_req           (hs_req),
    .hs_pid           (hs_pid),
    .data_req         (data_req),
    .data_len         (data_len),
    .buffer_occupancy (buffer_occupancy),
    .end_packet       (end_packet),
    .begin_packet     (begin_packet),
    .tx_packet        (tx_packet),
    .hs_ack           (hs_ack),
    .data_ack         (data_ack),
    .busy             (busy),
    .tx_timeout       (tx_timeout)
  );

  // Event kinds: 0 begin_packet, 1 hs_ack, 2 data_ack, 3 tx_timeout
  typedef struct {
    int kind;
    int pkt;
    int at;
  } ev_t;

  ev_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_ev(int kind, int pkt, int at);
    ev_t e;
    e.kind = kind;
    e.pkt  = pkt;
    e.at   = at;
    sb.push_back(e);
  endfunction

  function automatic void check_ev(int kind, int pkt);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d pkt=%0d at cycle %0d, required none", kind, pkt, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.at != cyc || (kind == 0 && e.pkt != pkt)) begin
        fails++;
        $display("FAIL event: got kind=%0d pkt=%0d cycle=%0d, required kind=%0d pkt=%0d cycle=%0d",
                 kind, pkt, cyc, e.kind, e.pkt, e.at);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (begin_packet) check_ev(0, int'(tx_packet));
    if (hs_ack)       check_ev(1, 0);
    if (data_ack)     check_ev(2, 0);
    if (tx_timeout)   check_ev(3, 0);
  end

  task automatic chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_to(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_end();
    end_packet = 1'b1;
    @(negedge clk);
    end_packet = 1'b0;
  endtask

  int c;
  int b;

  initial begin
    rst = 1'b1; hs_req = 1'b0; hs_pid = 2'd0; data_req = 1'b0;
    data_len = 7'd0; buffer_occupancy = 7'd0; end_packet = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({begin_packet, tx_packet, hs_ack, data_ack, busy, tx_timeout}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // NAK handshake, gap length, end_packet ignored in GAP
    c = cyc;
    hs_req = 1'b1; hs_pid = 2'd1;
    expect_ev(0, 3, c + 1);
    expect_ev(1, 0, c + 4);
    wait_to(c + 2);
    chk("nak_tx_packet_wait_end", int'(tx_packet), 3);
    wait_to(c + 3);
    pulse_end();
    hs_req = 1'b0;
    chk("gap_tx_packet_zero", int'(tx_packet), 0);
    wait_to(c + 6);
    pulse_end();
    wait_to(c + 11);
    chk("busy_last_gap_cycle", int'(busy), 1);
    wait_to(c + 12);
    chk("busy_after_gap", int'(busy), 0);
    wait_to(c + 14);

    // ACK beats simultaneous DATA0; DATA0 starts one cycle after GAP
    c = cyc;
    hs_req = 1'b1; hs_pid = 2'd0;
    data_req = 1'b1; data_len = 7'd4; buffer_occupancy = 7'd10;
    expect_ev(0, 2, c + 1);
    expect_ev(1, 0, c + 4);
    expect_ev(0, 1, c + 13);
    expect_ev(2, 0, c + 16);
    wait_to(c + 3);
    pulse_end();
    hs_req = 1'b0;
    wait_to(c + 15);
    pulse_end();
    data_req = 1'b0;
    wait_to(c + 26);

    // DATA0 gated by FIFO occupancy
    c = cyc;
    data_req = 1'b1; data_len = 7'd20; buffer_occupancy = 7'd19;
    wait_to(c + 5);
    chk("underfilled_not_busy", int'(busy), 0);
    buffer_occupancy = 7'd20;
    expect_ev(0, 1, c + 6);
    expect_ev(2, 0, c + 9);
    wait_to(c + 8);
    pulse_end();
    data_req = 1'b0;
    wait_to(c + 20);

    // Zero-length DATA0 times out, relaunches; second attempt ends on expiry cycle
    c = cyc;
    data_req = 1'b1; data_len = 7'd0; buffer_occupancy = 7'd0;
    b = c + 1035;
    expect_ev(0, 1, c + 1);
    expect_ev(3, 0, c + 1026);
    expect_ev(0, 1, b);
    expect_ev(2, 0, b + 1025);
    wait_to(c + 1027);
    chk("timeout_data_req_pending_busy", int'(busy), 1);
    wait_to(b + 1024);
    pulse_end();
    data_req = 1'b0;
    wait_to(b + 1040);

    // Reserved PID acked without transmit; DATA0 deferred one cycle
    c = cyc;
    hs_req = 1'b1; hs_pid = 2'd3;
    data_req = 1'b1; data_len = 7'd2; buffer_occupancy = 7'd5;
    expect_ev(1, 0, c + 1);
    expect_ev(0, 1, c + 2);
    expect_ev(2, 0, c + 5);
    wait_to(c + 1);
    hs_req = 1'b0;
    chk("reserved_idle_not_busy", int'(busy), 0);
    wait_to(c + 4);
    pulse_end();
    data_req = 1'b0;
    wait_to(c + 16);

    // Reset during WAIT_END aborts silently
    c = cyc;
    hs_req = 1'b1; hs_pid = 2'd2;
    expect_ev(0, 4, c + 1);
    wait_to(c + 3);
    chk("stall_tx_packet_wait_end", int'(tx_packet), 4);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({begin_packet, tx_packet, hs_ack, data_ack, busy, tx_timeout}), 0);
    @(negedge clk);
    rst = 1'b0; hs_req = 1'b0;
    pulse_end();
    repeat (4) @(negedge clk);
    chk("post_reset_idle", int'(busy), 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
